// File: rtl/alu_issue_sequencer.sv
// Execute-stage sequencer: owns the 16x64 register file, commits single-cycle ALU ops,
// runs imul on a shared multi-cycle multiplier writing rax/rdx, and halts on retq.
module alu_issue_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [3:0]          in_dst,
  input  logic [3:0]          in_src,
  input  logic                in_src_is_imm,
  input  logic [63:0]         in_imm,
  input  logic [3:0]          dbg_idx,
  output logic [63:0]         dbg_data,
  output logic                busy,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_MOV    = 3'd3;
  localparam logic [2:0] OP_MOVABS = 3'd4;
  localparam logic [2:0] OP_IMUL   = 3'd5;
  localparam logic [2:0] OP_RETQ   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [63:0]   regs [16];
  logic [3:0]    mul_cnt;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [127:0]  product;
  logic          accept;
  logic [63:0]   vala;
  logic [63:0]   valb;
  logic [63:0]   alu_res;
  logic          alu_we;
  logic          mul_start;
  logic          mul_done;
  logic          retire_inc;

  assign accept   = in_valid && in_ready;
  assign dbg_data = regs[dbg_idx];
  assign product  = {64'd0, mul_a} * {64'd0, mul_b};

  // Next-state and commit decode; operands come from the register file as committed.
  always_comb begin
    next_state = state;
    alu_we     = 1'b0;
    alu_res    = 64'd0;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    retire_inc = 1'b0;
    vala       = regs[in_dst];
    valb       = in_src_is_imm ? in_imm : regs[in_src];
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_op)
            OP_ADD: begin
              alu_we     = 1'b1;
              alu_res    = vala + valb;
              retire_inc = 1'b1;
            end
            OP_OR: begin
              alu_we     = 1'b1;
              alu_res    = vala | valb;
              retire_inc = 1'b1;
            end
            OP_AND: begin
              alu_we     = 1'b1;
              alu_res    = vala & valb;
              retire_inc = 1'b1;
            end
            OP_MOV, OP_MOVABS: begin
              alu_we     = 1'b1;
              alu_res    = valb;
              retire_inc = 1'b1;
            end
            OP_IMUL: begin
              mul_start  = 1'b1;
              next_state = MUL;
            end
            OP_RETQ: begin
              retire_inc = 1'b1;
              next_state = HALT;
            end
            default: begin
              retire_inc = 1'b1;
            end
          endcase
        end else begin
          next_state = IDLE;
        end
      end
      MUL: begin
        if (mul_cnt == 4'd0) begin
          mul_done   = 1'b1;
          retire_inc = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = MUL;
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, handshake flags, multiplier operands, retire counter and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      halted   <= 1'b0;
      retired  <= '0;
      mul_cnt  <= 4'd0;
      mul_a    <= 64'd0;
      mul_b    <= 64'd0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 64'd0;
      end
    end else begin
      state    <= next_state;
      in_ready <= (next_state == IDLE);
      busy     <= (next_state == MUL);
      halted   <= (next_state == HALT);
      if (retire_inc) begin
        retired <= retired + RETIRE_W'(1);
      end
      if (mul_start) begin
        mul_a   <= vala;
        mul_b   <= valb;
        mul_cnt <= 4'(MUL_LATENCY - 1);
      end else if ((state == MUL) && (mul_cnt != 4'd0)) begin
        mul_cnt <= mul_cnt - 4'd1;
      end
      if (alu_we) begin
        regs[in_dst] <= alu_res;
      end
      // rax/rdx are the fixed imul destinations regardless of in_dst.
      if (mul_done) begin
        regs[0] <= product[63:0];
        regs[2] <= product[127:64];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed and random checks of alu_issue_sequencer against a reference register-file model,
// with expected register values queued at issue and compared when the DUT commits.
module tb_alu_issue_sequencer;

  localparam int MUL_LAT = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_dst;
  logic [3:0]  in_src;
  logic        in_src_is_imm;
  logic [63:0] in_imm;
  logic [3:0]  dbg_idx;
  logic [63:0] dbg_data;
  logic        busy;
  logic        halted;
  logic [31:0] retired;

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] val;
  } sb_t;

  sb_t         sb[$];
  logic [63:0] m_regs [16];
  logic [31:0] m_retired;
  logic        m_halted;
  int          vectors;
  int          miscompares;

  alu_issue_sequencer #(.MUL_LATENCY(MUL_LAT), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src(in_src), .in_src_is_imm(in_src_is_imm),
    .in_imm(in_imm), .dbg_idx(dbg_idx), .dbg_data(dbg_data), .busy(busy),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_retired = 32'd0;
    m_halted  = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      dbg_idx = e.idx;
      #1;
      chk($sformatf("dbg_r%0d", e.idx), {64'd0, dbg_data}, {64'd0, e.val});
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {64'd0, dbg_data}, {64'd0, m_regs[i]});
    end
  endtask

  // Issue one instruction (caller guarantees the model is IDLE) and check its commit.
  task automatic send(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                      input logic isimm, input logic [63:0] imm);
    logic [63:0]  va;
    logic [63:0]  vb;
    logic [127:0] p;
    va = m_regs[dst];
    vb = isimm ? imm : m_regs[src];
    in_op = op; in_dst = dst; in_src = src; in_src_is_imm = isimm; in_imm = imm;
    in_valid = 1'b1;
    chk("in_ready_pre", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    case (op)
      3'd0: begin m_regs[dst] = va + vb; sb.push_back('{dst, m_regs[dst]}); end
      3'd1: begin m_regs[dst] = va | vb; sb.push_back('{dst, m_regs[dst]}); end
      3'd2: begin m_regs[dst] = va & vb; sb.push_back('{dst, m_regs[dst]}); end
      3'd3, 3'd4: begin m_regs[dst] = vb; sb.push_back('{dst, m_regs[dst]}); end
      3'd5: begin
        for (int k = 0; k < MUL_LAT; k++) begin
          chk("mul_busy", {127'd0, busy}, 128'd1);
          chk("mul_in_ready", {127'd0, in_ready}, 128'd0);
          in_op = 3'd0; in_dst = 4'd1; in_src_is_imm = 1'b1; in_imm = 64'd1;
          in_valid = 1'b1;
          dbg_idx = 4'd0;
          #1;
          chk("mul_frozen_r0", {64'd0, dbg_data}, {64'd0, m_regs[0]});
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        p = {64'd0, va} * {64'd0, vb};
        m_regs[0] = p[63:0];
        m_regs[2] = p[127:64];
        sb.push_back('{4'd0, m_regs[0]});
        sb.push_back('{4'd2, m_regs[2]});
        sb.push_back('{4'd1, m_regs[1]});
      end
      3'd6: m_halted = 1'b1;
      default: ;
    endcase
    m_retired = m_retired + 32'd1;
    drain();
    chk("retired", {96'd0, retired}, {96'd0, m_retired});
    chk("halted", {127'd0, halted}, {127'd0, m_halted});
    chk("busy_post", {127'd0, busy}, 128'd0);
    chk("in_ready_post", {127'd0, in_ready}, {127'd0, ~m_halted});
  endtask

  initial begin
    int          r;
    logic [2:0]  op;
    clk = 1'b0; reset = 1'b1; in_valid = 1'b0; in_op = 3'd7; in_dst = 4'd0; in_src = 4'd0;
    in_src_is_imm = 1'b0; in_imm = 64'd0; dbg_idx = 4'd0;
    vectors = 0; miscompares = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_halted", {127'd0, halted}, 128'd0);
    chk("rst_retired", {96'd0, retired}, 128'd0);
    check_all_regs("rst");

    // Back-to-back mov/add with carry discarded
    send(3'd3, 4'd1, 4'd0, 1'b1, 64'd5);
    send(3'd0, 4'd1, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("r1_is_4", {64'd0, m_regs[1]}, 128'd4);

    // Logic ops
    send(3'd4, 4'd3, 4'd0, 1'b1, 64'hF0F0);
    send(3'd1, 4'd3, 4'd0, 1'b1, 64'h0F0F);
    send(3'd2, 4'd3, 4'd0, 1'b1, 64'h00FF);
    send(3'd7, 4'd3, 4'd3, 1'b0, 64'd0);
    send(3'd0, 4'd3, 4'd3, 1'b0, 64'd0);

    // imul with rdx receiving the high half
    send(3'd4, 4'd0, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    send(3'd3, 4'd5, 4'd0, 1'b1, 64'd2);
    send(3'd5, 4'd0, 4'd5, 1'b0, 64'd0);
    send(3'd5, 4'd9, 4'd0, 1'b1, 64'd3);

    // Reset aborts an in-flight multiply
    send(3'd3, 4'd0, 4'd0, 1'b1, 64'd3);
    send(3'd3, 4'd5, 4'd0, 1'b1, 64'd7);
    in_op = 3'd5; in_dst = 4'd0; in_src = 4'd5; in_src_is_imm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("abort_retired", {96'd0, retired}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    repeat (MUL_LAT + 2) @(posedge clk);
    #1;
    check_all_regs("abort");

    // Random stream against the model, ending in retq
    for (int n = 0; n < 1000; n++) begin
      r  = $urandom_range(0, 6);
      op = (r == 6) ? 3'd7 : 3'(r);
      send(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    send(3'd6, 4'd0, 4'd0, 1'b0, 64'd0);
    check_all_regs("halt");

    // HALT absorbs further valid instructions
    in_op = 3'd0; in_dst = 4'd1; in_src_is_imm = 1'b1; in_imm = 64'd1; in_valid = 1'b1;
    dbg_idx = 4'd1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("halt_halted", {127'd0, halted}, 128'd1);
      chk("halt_in_ready", {127'd0, in_ready}, 128'd0);
      chk("halt_r1", {64'd0, dbg_data}, {64'd0, m_regs[1]});
      chk("halt_retired", {96'd0, retired}, {96'd0, m_retired});
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Execute-stage controller between the decoder and the integer ALU datapath.
- Owns the 16x64 architectural register file and accepts one decoded instruction at a time via a valid/ready handshake.
- Single-cycle ops (add/or/and/mov/movabs) commit in one cycle; imul runs on a shared multi-cycle multiplier.
- On retq it halts and raises a done flag for the testbench/top.

Parameters:
- MUL_LATENCY, 4, cycles from imul acceptance to rax/rdx writeback; legal range 1..15.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  sequencer can accept this cycle
- in_op  input  3  0=add 1=or 2=and 3=mov 4=movabs 5=imul 6=retq 7=nop
- in_dst  input  4  operand0 base register index
- in_src  input  4  operand1 base register index
- in_src_is_imm  input  1  1: operand1 = in_imm, 0: operand1 = reg[in_src]
- in_imm  input  64  immediate value
- dbg_idx  input  4  debug read index
- dbg_data  output  64  reg[dbg_idx], combinational
- busy  output  1  multiply in flight
- halted  output  1  retq retired
- retired  output  RETIRE_W  count of retired instructions

Behaviour:
- Reset (synchronous, active-high): all 16 registers = 0, state=IDLE, in_ready=1, busy=0, halted=0, retired=0, mul counter=0. Reset mid-multiply aborts it; no writeback.
- Accept = in_valid && in_ready, sampled at rising edge. in_ready is a registered/state-derived output, never combinationally dependent on in_valid.
- Operand values are read from the register file as it stands in the accept cycle:
  - vala = reg[in_dst]
  - valb = in_src_is_imm ? in_imm : reg[in_src]
- States:
  - IDLE (in_ready=1):
    - add/or/and: reg[in_dst] <= vala op valb; add is modulo 2^64, carry discarded.
    - mov/movabs: reg[in_dst] <= valb.
    - nop: no register change.
    - In all of the above: stay IDLE, retired += 1, commit visible on dbg_data the cycle after accept. Back-to-back accepts every cycle are legal, and the second instruction sees the first's result (no hazard).
    - imul: latch vala and valb, load counter = MUL_LATENCY-1, go to MUL.
    - retq: retired += 1, go to HALT.
  - MUL (in_ready=0, busy=1): counter decrements each cycle.
    - At counter==0: product = zero-extended 128-bit vala*valb (unsigned); reg[0] (rax) <= product[63:0], reg[2] (rdx) <= product[127:64]; retired += 1; go to IDLE.
    - The first accept after a multiply occurs the cycle after the writeback edge.
    - Total: imul accepted at edge N writes at edge N+MUL_LATENCY, and in_ready rises after that edge.
    - If MUL_LATENCY=1: write on the edge after accept, so in_ready is low for exactly one cycle.
    - Register contents are frozen except at writeback.
  - HALT (in_ready=0, halted=1): absorbing until reset. in_valid is ignored and registers are stable.
- in_op 7 and any in_dst/in_src combination are legal. in_dst==in_src reads the old value.
- retired wraps modulo 2^RETIRE_W.
- Register 0/2 as the imul destination overrides in_dst; in_dst is ignored for imul.
- dbg_data reflects committed state only (no bypass of in-flight results).

Test Plan:
- Reset, then mov r1,imm 5; add r1,imm 0xFFFFFFFFFFFFFFFF (in consecutive cycles) -> dbg r1 = 4 after second edge, retired=2, in_ready held 1.
- mov r3,0xF0F0; or r3,imm 0x0F0F; and r3,imm 0x00FF -> r3 = 0x00FF, each committing one cycle after accept.
- MUL_LATENCY=4: r0=0xFFFFFFFFFFFFFFFF, r5=2, imul r0,r5 -> in_ready low 4 cycles, busy=1, then r0=0xFFFFFFFFFFFFFFFE, r2=1, retired incremented once; in_valid held high during MUL is not accepted.
- imul in flight, assert reset at cycle 2 -> next cycle all regs 0, state IDLE, retired=0, no late writeback.
- retq followed by in_valid add r1,imm 1 held for 10 cycles -> halted=1, in_ready=0, r1 unchanged, retired counts retq only.
- Random stream of 1000 ops with random valid gaps vs. a reference model -> register file and retired count match exactly at halt.
